// File: rtl/tilt_pkg.sv
// Shared types and default timing constants for the tilt event source.
package tilt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 1_000_000;

endpackage

// File: rtl/tilt_debounce.sv
// Two-flop synchronizer plus counter debouncer for the raw tilt level;
// emits the accepted level and a one-cycle pulse on its rising transition.
module tilt_debounce
  import tilt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tilt_raw,
  output logic tilt_stable,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          tilt_sync;
  logic          stable_d;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      tilt_sync <= 1'b0;
    end else begin
      sync1     <= tilt_raw;
      tilt_sync <= sync1;
    end
  end

  // Any sample agreeing with the accepted level restarts the count, so glitches never accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt      <= '0;
      tilt_stable <= 1'b0;
    end else if (tilt_sync == tilt_stable) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt      <= '0;
      tilt_stable <= tilt_sync;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_d <= 1'b0;
    else       stable_d <= tilt_stable;
  end

  assign rise = tilt_stable & ~stable_d;

endmodule

// File: rtl/tilt_event_source.sv
// Turns debounced tilt rising edges into start/done handshakes with a tilt
// counter, capturing results and tracking timeouts and lost edges.
module tilt_event_source
  import tilt_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tilt_raw,
  output logic             start,
  input  logic             done,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] last_count,
  output logic [WIDTH-1:0] event_total,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun,
  input  logic             clear_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t           state, state_next;
  logic             pending, pending_next;
  logic [TW-1:0]    wait_cnt, wait_cnt_next;
  logic [WIDTH-1:0] last_count_next, event_total_next;
  logic             timeout_set, overrun_set;
  logic             tilt_stable, rise, accept;

  tilt_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .tilt_raw   (tilt_raw),
    .tilt_stable(tilt_stable),
    .rise       (rise)
  );

  assign accept = rise & tilt_stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    pending_next     = pending;
    wait_cnt_next    = wait_cnt;
    last_count_next  = last_count;
    event_total_next = event_total;
    timeout_set      = 1'b0;
    overrun_set      = 1'b0;
    unique case (state)
      IDLE: begin
        // A fresh edge arriving together with a queued one stays queued.
        if (accept || pending) begin
          state_next   = ISSUE;
          pending_next = accept && pending;
        end
      end
      ISSUE: begin
        state_next    = WAIT;
        wait_cnt_next = '0;
      end
      WAIT: begin
        wait_cnt_next = wait_cnt + TW'(1);
        if (done) begin
          state_next      = IDLE;
          last_count_next = count_in;
          if (event_total != '1) event_total_next = event_total + WIDTH'(1);
        end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next  = IDLE;
          timeout_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state != IDLE && accept) begin
      if (pending) overrun_set  = 1'b1;
      else         pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= 1'b0;
      wait_cnt    <= '0;
      last_count  <= '0;
      event_total <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      pending     <= pending_next;
      wait_cnt    <= wait_cnt_next;
      last_count  <= last_count_next;
      event_total <= event_total_next;
      timeout_err <= timeout_set | (timeout_err & ~clear_err);
      overrun     <= overrun_set | (overrun & ~clear_err);
    end
  end

  assign start = (state == ISSUE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_tilt_event_source.sv
// Scenario bench for tilt_event_source; a second instance with a longer
// timeout hosts the multi-edge overrun scenario.
module tb_tilt_event_source;

  localparam int unsigned D     = 4;
  localparam int unsigned T     = 8;
  localparam int unsigned T_OVR = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tilt_raw = 1'b0, done = 1'b0, clear_err = 1'b0;
  logic [31:0] count_in = '0;
  logic        start, busy, timeout_err, overrun;
  logic [31:0] last_count, event_total;

  logic        o_raw = 1'b0, o_done = 1'b0, o_clear = 1'b0;
  logic [31:0] o_count = '0;
  logic        o_start, o_busy, o_terr, o_overrun;
  logic [31:0] o_last, o_total;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int o_starts = 0;

  typedef struct {
    logic [31:0] last;
    logic [31:0] total;
    logic        terr;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_last = '0;
  logic [31:0] exp_total = '0;

  tilt_event_source #(.WIDTH(32), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .tilt_raw(tilt_raw), .start(start), .done(done),
    .count_in(count_in), .last_count(last_count), .event_total(event_total),
    .busy(busy), .timeout_err(timeout_err), .overrun(overrun), .clear_err(clear_err)
  );

  tilt_event_source #(.WIDTH(32), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T_OVR)) u_ovr (
    .clk(clk), .reset(reset), .tilt_raw(o_raw), .start(o_start), .done(o_done),
    .count_in(o_count), .last_count(o_last), .event_total(o_total),
    .busy(o_busy), .timeout_err(o_terr), .overrun(o_overrun), .clear_err(o_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;
  always @(negedge clk) if (o_start === 1'b1) o_starts++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input bit which, output int s, output bit ok);
    ok = 1'b0;
    s  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((which ? o_start : start) === 1'b1) begin
        ok = 1'b1;
        s  = edge_cnt;
        break;
      end
    end
  endtask

  function automatic void push_done(input logic [31:0] val);
    exp_last = val;
    if (exp_total != 32'hFFFF_FFFF) exp_total = exp_total + 32'd1;
    exp_q.push_back('{exp_last, exp_total, 1'b0});
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (last_count !== 32'h0) begin errors++; $display("FAIL reset_last_count: got %h want 0", last_count); end
    checks++; if (event_total !== 32'h0) begin errors++; $display("FAIL reset_event_total: got %h want 0", event_total); end
  endtask

  task automatic test_basic();
    int s, k;
    bit ok;
    exp_t e;
    tilt_raw = 1'b1;
    k = edge_cnt + 1;
    wait_start(1'b0, s, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_start_seen: got none want start"); end
    else if (s != k + int'(D) + 2) begin errors++; $display("FAIL basic_latency: got edge %0d want edge %0d", s, k + int'(D) + 2); end
    tick();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL basic_start_width: got %b want 0", start); end
    tick(2);
    done = 1'b1; count_in = 32'h2A; push_done(32'h2A);
    tick();
    done = 1'b0; count_in = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
    e = exp_q.pop_front();
    checks++; if (last_count !== e.last) begin errors++; $display("FAIL basic_last_count: got %h want %h", last_count, e.last); end
    checks++; if (event_total !== e.total) begin errors++; $display("FAIL basic_event_total: got %h want %h", event_total, e.total); end
    tilt_raw = 1'b0;
    tick(12);
  endtask

  task automatic test_glitch();
    bit saw_start = 1'b0, saw_stable = 1'b0;
    tilt_raw = 1'b1;
    tick(3);
    tilt_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start !== 1'b0) saw_start = 1'b1;
      if (dut.u_debounce.tilt_stable !== 1'b0) saw_stable = 1'b1;
    end
    checks++; if (saw_start) begin errors++; $display("FAIL glitch_start: got start want none"); end
    checks++; if (saw_stable) begin errors++; $display("FAIL glitch_stable: got 1 want 0"); end
    done = 1'b1; count_in = 32'h123;
    tick();
    done = 1'b0; count_in = '0;
    tick();
    checks++; if (last_count !== exp_last) begin errors++; $display("FAIL idle_done_last_count: got %h want %h", last_count, exp_last); end
    checks++; if (event_total !== exp_total) begin errors++; $display("FAIL idle_done_event_total: got %h want %h", event_total, exp_total); end
  endtask

  task automatic test_timeout();
    int s;
    bit ok;
    exp_t e;
    tilt_raw = 1'b1;
    wait_start(1'b0, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_start_seen: got none want start"); end
    exp_q.push_back('{exp_last, exp_total, 1'b1});
    tick(int'(T));
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_last_wait_busy: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy %b want 0", busy); end
    e = exp_q.pop_front();
    checks++; if (timeout_err !== e.terr) begin errors++; $display("FAIL timeout_flag: got %b want %b", timeout_err, e.terr); end
    checks++; if (event_total !== e.total) begin errors++; $display("FAIL timeout_event_total: got %h want %h", event_total, e.total); end
    checks++; if (last_count !== e.last) begin errors++; $display("FAIL timeout_last_count: got %h want %h", last_count, e.last); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    tilt_raw = 1'b0;
    tick(12);
  endtask

  task automatic test_overrun();
    int s, base;
    bit ok;
    base = o_starts;
    o_raw = 1'b1;
    wait_start(1'b1, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun_first_start: got none want start"); end
    o_raw = 1'b0; tick(6);
    o_raw = 1'b1; tick(6);
    o_raw = 1'b0; tick(6);
    o_raw = 1'b1; tick(8);
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", o_overrun); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL overrun_still_waiting: got busy %b want 1", o_busy); end
    o_done = 1'b1; o_count = 32'h55;
    tick();
    o_done = 1'b0; o_count = '0;
    wait_start(1'b1, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun_second_start: got none want start"); end
    tick(3);
    o_done = 1'b1; o_count = 32'h66;
    tick();
    o_done = 1'b0; o_count = '0;
    tick(10);
    checks++; if (o_starts - base != 2) begin errors++; $display("FAIL overrun_start_count: got %0d want 2", o_starts - base); end
    checks++; if (o_total !== 32'd2) begin errors++; $display("FAIL overrun_event_total: got %h want 2", o_total); end
    checks++; if (o_last !== 32'h66) begin errors++; $display("FAIL overrun_last_count: got %h want 66", o_last); end
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", o_overrun); end
    o_raw = 1'b0;
    tick(12);
  endtask

  task automatic test_collision();
    int s;
    bit ok;
    exp_t e;
    tilt_raw = 1'b1;
    wait_start(1'b0, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL collision_start_seen: got none want start"); end
    tick(int'(T));
    done = 1'b1; count_in = 32'h77; push_done(32'h77);
    tick();
    done = 1'b0; count_in = '0;
    e = exp_q.pop_front();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collision_busy: got %b want 0", busy); end
    checks++; if (last_count !== e.last) begin errors++; $display("FAIL collision_last_count: got %h want %h", last_count, e.last); end
    checks++; if (event_total !== e.total) begin errors++; $display("FAIL collision_event_total: got %h want %h", event_total, e.total); end
    checks++; if (timeout_err !== e.terr) begin errors++; $display("FAIL collision_timeout_err: got %b want %b", timeout_err, e.terr); end
    tilt_raw = 1'b0;
    tick(10);
    tilt_raw = 1'b1;
    wait_start(1'b0, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midwait_start_seen: got none want start"); end
    tick(3);
    tilt_raw = 1'b0;
    reset = 1'b1;
    #1;
    exp_last = '0; exp_total = '0; exp_q.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midwait_reset_busy: got %b want 0", busy); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL midwait_reset_start: got %b want 0", start); end
    checks++; if (last_count !== exp_last) begin errors++; $display("FAIL midwait_reset_last_count: got %h want %h", last_count, exp_last); end
    checks++; if (event_total !== exp_total) begin errors++; $display("FAIL midwait_reset_event_total: got %h want %h", event_total, exp_total); end
    checks++; if (timeout_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midwait_reset_flags: got %b%b want 00", timeout_err, overrun); end
    tick();
    reset = 1'b0;
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL after_reset_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_saturation();
    int s;
    bit ok;
    exp_t e;
    force dut.event_total = 32'hFFFF_FFFF;
    tick();
    release dut.event_total;
    exp_total = 32'hFFFF_FFFF;
    tick();
    checks++; if (event_total !== exp_total) begin errors++; $display("FAIL sat_preload: got %h want %h", event_total, exp_total); end
    tilt_raw = 1'b1;
    wait_start(1'b0, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_start_seen: got none want start"); end
    tick(2);
    done = 1'b1; count_in = 32'h99; push_done(32'h99);
    tick();
    done = 1'b0; count_in = '0;
    e = exp_q.pop_front();
    checks++; if (event_total !== e.total) begin errors++; $display("FAIL sat_event_total: got %h want %h", event_total, e.total); end
    checks++; if (last_count !== e.last) begin errors++; $display("FAIL sat_last_count: got %h want %h", last_count, e.last); end
    tilt_raw = 1'b0;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_timeout();
    test_overrun();
    test_collision();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tilt_event_source.md
TILT_EVENT_SOURCE -- requirements
Module: tilt_event_source

Interface
REQ-001 Parameter WIDTH, 32, width of count_in, last_count and event_total.
REQ-002 Parameter DEBOUNCE_CYCLES, 500_000, clock cycles tilt input must be stable before acceptance (10 ms at 50 MHz); legal range >= 2.
REQ-003 Parameter TIMEOUT_CYCLES, 1_000_000, maximum cycles spent waiting for done after start; legal range >= 2.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tilt_raw  in  1  asynchronous raw tilt sensor level.
REQ-007 start  out  1  one-cycle request strobe to the tilt counter.
REQ-008 done  in  1  completion strobe from the tilt counter.
REQ-009 count_in  in  WIDTH  counter result, valid in the done cycle.
REQ-010 last_count  out  WIDTH  count_in captured at the last accepted done.
REQ-011 event_total  out  WIDTH  number of completed requests, saturating.
REQ-012 busy  out  1  high when state is not IDLE.
REQ-013 timeout_err  out  1  sticky flag, set when done never arrived.
REQ-014 overrun  out  1  sticky flag, set when a tilt edge was lost.
REQ-015 clear_err  in  1  synchronous clear of timeout_err and overrun.

Function
REQ-016 tilt_raw SHALL pass through a 2-flop synchronizer; the second flop output is tilt_sync.
REQ-017 Debounce: while tilt_sync equals tilt_stable, db_cnt SHALL be 0; while they differ, db_cnt SHALL increment each cycle; on the edge where db_cnt == DEBOUNCE_CYCLES-1 and they still differ, tilt_stable SHALL take tilt_sync and db_cnt SHALL clear.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles on tilt_sync SHALL NOT change tilt_stable and SHALL restart db_cnt at 0.
REQ-019 rise SHALL be a one-cycle pulse on a 0->1 transition of tilt_stable; a falling transition SHALL generate nothing.
REQ-020 FSM states are IDLE, ISSUE and WAIT.
REQ-021 IDLE -> ISSUE on rise or on pending=1; pending SHALL clear on that transition.
REQ-022 ISSUE SHALL last exactly one cycle with start=1, then go to WAIT; start SHALL be 0 in all other states.
REQ-023 WAIT: wait_cnt SHALL clear on entry and increment each cycle.
REQ-024 WAIT with done=1 -> IDLE, capturing last_count <= count_in and incrementing event_total (held at all-ones).
REQ-025 WAIT with done=0 and wait_cnt == TIMEOUT_CYCLES-1 -> IDLE, setting timeout_err; last_count and event_total SHALL be unchanged.
REQ-026 done and timeout in the same cycle: done SHALL win and timeout_err SHALL NOT be set.
REQ-027 done in IDLE or ISSUE SHALL be ignored.
REQ-028 rise in ISSUE or WAIT SHALL set pending (one deep); rise while pending=1 SHALL set overrun and be dropped.
REQ-029 clear_err SHALL clear both sticky flags; when a set and clear_err coincide, the set SHALL win.
REQ-030 Latency: if edge k is the first edge sampling tilt_raw=1 and tilt_raw then stays high, start SHALL be high in the cycle after edge k+DEBOUNCE_CYCLES+2.

Reset
REQ-031 Reset SHALL force the following values: start=0, busy=0, timeout_err=0, overrun=0, last_count=0, event_total=0, state=IDLE, pending=0, db_cnt=0, wait_cnt=0, synchronizer flops=0 and tilt_stable=0.
REQ-032 Reset asserted mid-WAIT SHALL abandon the request with no capture, and the block SHALL resume in IDLE.

Structure
REQ-033 Package tilt_pkg SHALL hold the FSM state enum and the default DEBOUNCE_CYCLES and TIMEOUT_CYCLES constants.
REQ-034 The synchronizer and debouncer SHALL be one sub-module, tilt_debounce (outputs tilt_stable and rise); the FSM and counters stay in the top.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8, WIDTH=32)
REQ-035 Basic: tilt_raw high at edge 10, done with count_in=0x2A three cycles after start -> start high after edge 16, last_count=0x2A, event_total=1, busy=0.
REQ-036 Glitch: tilt_raw high for 3 cycles then low -> no start, tilt_stable stays 0.
REQ-037 Timeout: start issued, done never asserted -> IDLE after 8 WAIT cycles, timeout_err=1, event_total unchanged; clear_err -> timeout_err=0.
REQ-038 Overrun: three debounced rises during one WAIT -> second ISSUE follows the first done, overrun=1, two starts total.
REQ-039 Collision: done on the final WAIT cycle -> capture, timeout_err=0; reset pulse mid-WAIT -> all outputs 0, state IDLE.
REQ-040 Saturation: event_total preloaded to 0xFFFFFFFF, one more done -> event_total stays 0xFFFFFFFF.
